// File: rtl/elink_tx_arbiter.sv
// elink_tx_arbiter
// Round-robin arbiter that shares the eLink transmit path between NREQ
// requesters. Each requester presents a complete 112-bit eMesh frame. The
// winning frame is captured and sent to the serializer as two 64-bit beats:
//   beat 0 = frame[111:48],             mask 8'hFF
//   beat 1 = {frame[47:0], 16'h0000},   mask 8'hFC (6 bytes, MSB-aligned)
// This is the layout that elink_aligner reassembles on the receive side.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_frame   per-requester frame valid / frame (i at [i*112 +: 112])
//   req_ready             one-hot accept strobe (combinational)
//   tx_data/mask/valid    beat toward the serializer (registered)
//   tx_ready              serializer beat accept
//   grant_id              requester whose frame is in flight
//   busy                  high while a frame is being sent (HEAD or TAIL)
//   frame_count           frames fully transmitted, wraps modulo 2^CNT_W
module elink_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*112-1:0] req_frame,
  output logic [NREQ-1:0]     req_ready,
  output logic [63:0]         tx_data,
  output logic [7:0]          tx_mask,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [111:0]      frame_r;
  logic [111:0]      frame_s;
  logic [111:0]      sel_frame_s;
  logic [ID_W-1:0]   grant_r;
  logic [ID_W-1:0]   rr_last_r;
  logic [ID_W-1:0]   winner_s;
  logic [CNT_W-1:0]  count_r;
  logic              accept_en_s;
  logic              accept_s;
  logic [63:0]       tx_data_r;
  logic [63:0]       tx_data_s;
  logic [7:0]        tx_mask_r;
  logic [7:0]        tx_mask_s;
  logic              tx_valid_r;
  logic              tx_valid_s;
  logic              busy_r;
  logic              busy_s;

  // Round-robin search: walk from the farthest candidate back to the nearest
  // one so that the nearest valid requester after rr_last is the last writer.
  always_comb begin
    winner_s = rr_last_r;
    for (int k = NREQ; k >= 1; k--) begin
      winner_s = req_valid[ID_W'((int'(rr_last_r) + k) % NREQ)]
                 ? ID_W'((int'(rr_last_r) + k) % NREQ) : winner_s;
    end
  end

  // Accept decision, captured-frame next value and next-state logic.
  always_comb begin
    accept_en_s = (state_r == IDLE) | ((state_r == TAIL) & tx_ready);
    accept_s    = accept_en_s & (|req_valid);
    sel_frame_s = req_frame[int'(winner_s)*112 +: 112];
    frame_s     = accept_s ? sel_frame_s : frame_r;
    state_s     = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = HEAD;
        else          state_s = IDLE;
      end
      HEAD: begin
        if (tx_ready) state_s = TAIL;
        else          state_s = HEAD;
      end
      TAIL: begin
        if (!tx_ready)     state_s = TAIL;
        else if (accept_s) state_s = HEAD;
        else               state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Beat outputs for the next state, so the registered outputs line up with
  // the state register and stay stable while the serializer stalls.
  always_comb begin
    tx_data_s  = 64'h0;
    tx_mask_s  = 8'h00;
    tx_valid_s = 1'b0;
    busy_s     = 1'b0;
    case (state_s)
      HEAD: begin
        tx_data_s  = frame_s[111:48];
        tx_mask_s  = 8'hFF;
        tx_valid_s = 1'b1;
        busy_s     = 1'b1;
      end
      TAIL: begin
        tx_data_s  = {frame_s[47:0], 16'h0000};
        tx_mask_s  = 8'hFC;
        tx_valid_s = 1'b1;
        busy_s     = 1'b1;
      end
      default: begin
        tx_data_s  = 64'h0;
        tx_mask_s  = 8'h00;
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State, frame, arbitration history, counter and registered beat outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      frame_r    <= 112'h0;
      grant_r    <= {ID_W{1'b0}};
      rr_last_r  <= ID_W'(NREQ - 1);
      count_r    <= {CNT_W{1'b0}};
      tx_data_r  <= 64'h0;
      tx_mask_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      frame_r    <= frame_s;
      tx_data_r  <= tx_data_s;
      tx_mask_r  <= tx_mask_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      if (accept_s) begin
        grant_r   <= winner_s;
        rr_last_r <= winner_s;
      end
      if ((state_r == TAIL) && tx_ready) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign req_ready   = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << winner_s) : {NREQ{1'b0}};
  assign tx_data     = tx_data_r;
  assign tx_mask     = tx_mask_r;
  assign tx_valid    = tx_valid_r;
  assign grant_id    = grant_r;
  assign busy        = busy_r;
  assign frame_count = count_r;

endmodule
